// File: rtl/exe_wb_reg_pkg.sv
// Shared pipeline definitions for the EXE/WB boundary: select widths,
// writeback / data-memory select encodings and the bubble instruction.
package exe_wb_reg_pkg;

    localparam int DMEM_SEL_W = 2;
    localparam int LOAD_SEL_W = 3;
    localparam int WB_SEL_W   = 2;
    localparam int REG_IDX_W  = 5;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_SEL_IMM = 2'd0,
        WB_SEL_PC4 = 2'd1,
        WB_SEL_MEM = 2'd2,
        WB_SEL_ALU = 2'd3
    } wb_sel_e;

    typedef enum logic [DMEM_SEL_W-1:0] {
        DMEM_SEL_IO   = 2'd0,
        DMEM_SEL_DMEM = 2'd1,
        DMEM_SEL_BIOS = 2'd2
    } dmem_sel_e;

endpackage

// File: rtl/exe_wb_reg_fwd_compare.sv
// Forwarding comparator: asserts when the WB stage will write the register
// the EXE operand reads. Register x0 never forwards.
module fwd_compare
    import exe_wb_reg_pkg::*;
(
    input  logic                 valid_wb,
    input  logic                 regwen_wb,
    input  logic [REG_IDX_W-1:0] rd_wb,
    input  logic [REG_IDX_W-1:0] rs_id,
    output logic                 fwd
);

    assign fwd = valid_wb & regwen_wb & (rd_wb != '0) & (rd_wb == rs_id);

endmodule

// File: rtl/exe_wb_reg.sv
// EXE->WB pipeline register with stall/flush, bubble tracking and WB->EXE
// forwarding. Optional perf counters enabled by EXE_WB_PERF_CNT_EN.
module exe_wb_reg
    import exe_wb_reg_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = exe_wb_reg_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [XLEN-1:0]       pc_exe,
    input  logic [XLEN-1:0]       inst_exe,
    input  logic [XLEN-1:0]       imme_exe,
    input  logic [XLEN-1:0]       alu_exe,
    input  logic [DMEM_SEL_W-1:0] dmem_sel_exe,
    input  logic [LOAD_SEL_W-1:0] load_sel_exe,
    input  logic [WB_SEL_W-1:0]   wb_sel_exe,
    input  logic                  regwen_exe,
    input  logic [REG_IDX_W-1:0]  rd_exe,
    input  logic [REG_IDX_W-1:0]  rs1_id,
    input  logic [REG_IDX_W-1:0]  rs2_id,
    output logic [XLEN-1:0]       pc_wb,
    output logic [XLEN-1:0]       inst_wb,
    output logic [XLEN-1:0]       imme_wb,
    output logic [XLEN-1:0]       alu_wb,
    output logic [DMEM_SEL_W-1:0] dmem_sel_wb,
    output logic [LOAD_SEL_W-1:0] load_sel_wb,
    output logic [WB_SEL_W-1:0]   wb_sel_wb,
    output logic                  regwen_wb,
    output logic [REG_IDX_W-1:0]  rd_wb,
    output logic                  valid_wb,
`ifdef EXE_WB_PERF_CNT_EN
    output logic [31:0]           retired_cnt,
    output logic [31:0]           bubble_cnt,
`endif
    output logic                  fwd_rs1,
    output logic                  fwd_rs2
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

    logic kill;
    assign kill = flush | (inst_exe == NOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_wb       <= '0;
            inst_wb     <= NOP;
            imme_wb     <= '0;
            alu_wb      <= '0;
            dmem_sel_wb <= '0;
            load_sel_wb <= '0;
            wb_sel_wb   <= '0;
            regwen_wb   <= 1'b0;
            rd_wb       <= '0;
            valid_wb    <= 1'b0;
        end else if (!stall) begin
            pc_wb   <= pc_exe;
            imme_wb <= imme_exe;
            alu_wb  <= alu_exe;
            // A flushed slot and an incoming bubble look identical downstream.
            if (kill) begin
                inst_wb     <= NOP;
                dmem_sel_wb <= '0;
                load_sel_wb <= '0;
                wb_sel_wb   <= '0;
                regwen_wb   <= 1'b0;
                rd_wb       <= '0;
                valid_wb    <= 1'b0;
            end else begin
                inst_wb     <= inst_exe;
                dmem_sel_wb <= dmem_sel_exe;
                load_sel_wb <= load_sel_exe;
                wb_sel_wb   <= wb_sel_exe;
                regwen_wb   <= regwen_exe;
                rd_wb       <= rd_exe;
                valid_wb    <= 1'b1;
            end
        end
    end

`ifdef EXE_WB_PERF_CNT_EN
    // Counts the instruction leaving WB on each non-stalled edge; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            bubble_cnt  <= '0;
        end else if (!stall) begin
            if (valid_wb) retired_cnt <= retired_cnt + 32'd1;
            else          bubble_cnt  <= bubble_cnt + 32'd1;
        end
    end
`endif

    fwd_compare u_fwd_rs1 (
        .valid_wb  (valid_wb),
        .regwen_wb (regwen_wb),
        .rd_wb     (rd_wb),
        .rs_id     (rs1_id),
        .fwd       (fwd_rs1)
    );

    fwd_compare u_fwd_rs2 (
        .valid_wb  (valid_wb),
        .regwen_wb (regwen_wb),
        .rd_wb     (rd_wb),
        .rs_id     (rs2_id),
        .fwd       (fwd_rs2)
    );

endmodule

// File: tb/tb_exe_wb_reg.sv
// Directed bench for exe_wb_reg: reset, capture, stall, flush, bubble and
// forwarding; counter checks when EXE_WB_PERF_CNT_EN is defined.
module tb_exe_wb_reg;
    import exe_wb_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic [31:0] pc_exe, inst_exe, imme_exe, alu_exe;
    logic [1:0]  dmem_sel_exe, wb_sel_exe;
    logic [2:0]  load_sel_exe;
    logic        regwen_exe;
    logic [4:0]  rd_exe, rs1_id, rs2_id;
    logic [31:0] pc_wb, inst_wb, imme_wb, alu_wb;
    logic [1:0]  dmem_sel_wb, wb_sel_wb;
    logic [2:0]  load_sel_wb;
    logic        regwen_wb, valid_wb, fwd_rs1, fwd_rs2;
    logic [4:0]  rd_wb;
`ifdef EXE_WB_PERF_CNT_EN
    logic [31:0] retired_cnt, bubble_cnt;
    logic [31:0] ret0, bub0;
`endif

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] ADDI = 32'h00A0_0093;
    localparam logic [31:0] LW   = 32'h0005_2283;

    always #5 clk = ~clk;

    exe_wb_reg #(.XLEN(32), .NOP_INST(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .pc_exe(pc_exe), .inst_exe(inst_exe), .imme_exe(imme_exe), .alu_exe(alu_exe),
        .dmem_sel_exe(dmem_sel_exe), .load_sel_exe(load_sel_exe), .wb_sel_exe(wb_sel_exe),
        .regwen_exe(regwen_exe), .rd_exe(rd_exe), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .pc_wb(pc_wb), .inst_wb(inst_wb), .imme_wb(imme_wb), .alu_wb(alu_wb),
        .dmem_sel_wb(dmem_sel_wb), .load_sel_wb(load_sel_wb), .wb_sel_wb(wb_sel_wb),
        .regwen_wb(regwen_wb), .rd_wb(rd_wb), .valid_wb(valid_wb),
`ifdef EXE_WB_PERF_CNT_EN
        .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt),
`endif
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [1:0] wbs,
                         input logic rw, input logic [4:0] rd);
        inst_exe   = inst;
        wb_sel_exe = wbs;
        regwen_exe = rw;
        rd_exe     = rd;
    endtask

    initial begin
        // Reset with every input non-zero
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_exe = 32'h100; inst_exe = LW; imme_exe = 32'h44; alu_exe = 32'h55;
        dmem_sel_exe = DMEM_SEL_DMEM; load_sel_exe = 3'd2; wb_sel_exe = WB_SEL_MEM;
        regwen_exe = 1'b1; rd_exe = 5'd5; rs1_id = 5'd5; rs2_id = 5'd5;
        step(); step();
        chk("rst_inst",   inst_wb, 32'h0);
        chk("rst_valid",  {31'd0, valid_wb}, 32'd0);
        chk("rst_pc",     pc_wb, 32'h0);
        chk("rst_alu",    alu_wb, 32'h0);
        chk("rst_imme",   imme_wb, 32'h0);
        chk("rst_ctrl",   {20'd0, dmem_sel_wb, load_sel_wb, wb_sel_wb, regwen_wb, rd_wb}, 32'd0);
        chk("rst_fwd",    {30'd0, fwd_rs1, fwd_rs2}, 32'd0);

        // Release mid-cycle; first capture at the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        drive(ADDI, WB_SEL_ALU, 1'b1, 5'd1);
        dmem_sel_exe = DMEM_SEL_IO; load_sel_exe = 3'd0;
        chk("rel_no_capture", inst_wb, 32'h0);
        step();
        chk("addi_inst",  inst_wb, ADDI);
        chk("addi_valid", {31'd0, valid_wb}, 32'd1);
        chk("addi_rd",    {27'd0, rd_wb}, 32'd1);
        chk("addi_pc",    pc_wb, 32'h100);

        // Stall holds for three cycles
        alu_exe = 32'h1234;
        step();
        chk("stall_cap", alu_wb, 32'h1234);
        stall = 1'b1; alu_exe = 32'hFFFF; pc_exe = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_alu", alu_wb, 32'h1234);
            chk("stall_hold_pc",  pc_wb, 32'h100);
        end
        stall = 1'b0;
        step();
        chk("stall_release", alu_wb, 32'hFFFF);

        // Flush of a valid lw
        drive(LW, WB_SEL_MEM, 1'b1, 5'd5);
        dmem_sel_exe = DMEM_SEL_DMEM; load_sel_exe = 3'd2;
        flush = 1'b1;
        step();
        chk("flush_inst",   inst_wb, 32'h0);
        chk("flush_regwen", {31'd0, regwen_wb}, 32'd0);
        chk("flush_wbsel",  {30'd0, wb_sel_wb}, 32'd0);
        chk("flush_valid",  {31'd0, valid_wb}, 32'd0);
        chk("flush_ctrl",   {25'd0, dmem_sel_wb, load_sel_wb, rd_wb == 5'd0}, 32'd1);

        // Capture lw, then flush with stall: stall wins
        flush = 1'b0;
        step();
        chk("lw_inst",  inst_wb, LW);
        chk("lw_wbsel", {30'd0, wb_sel_wb}, {30'd0, WB_SEL_MEM});
        flush = 1'b1; stall = 1'b1; drive(ADDI, WB_SEL_ALU, 1'b1, 5'd1);
        step();
        chk("flushstall_inst",   inst_wb, LW);
        chk("flushstall_valid",  {31'd0, valid_wb}, 32'd1);
        chk("flushstall_regwen", {31'd0, regwen_wb}, 32'd1);

        // Forwarding from held lw (rd=5) during the stall
        rs1_id = 5'd5; rs2_id = 5'd6; #1;
        chk("fwd_rs1_hit",  {31'd0, fwd_rs1}, 32'd1);
        chk("fwd_rs2_miss", {31'd0, fwd_rs2}, 32'd0);
        rs2_id = 5'd5; #1;
        chk("fwd_rs2_hit",  {31'd0, fwd_rs2}, 32'd1);

        // x0 never forwards
        stall = 1'b0; flush = 1'b0;
        drive(32'h0000_0013, WB_SEL_ALU, 1'b1, 5'd0);
        step();
        rs1_id = 5'd0; rs2_id = 5'd0; #1;
        chk("fwd_x0_valid", {31'd0, valid_wb}, 32'd1);
        chk("fwd_x0",       {30'd0, fwd_rs1, fwd_rs2}, 32'd0);

        // Incoming bubble with live-looking controls behaves like a flush
        drive(32'h0, WB_SEL_MEM, 1'b1, 5'd5);
        step();
        rs1_id = 5'd5; rs2_id = 5'd5; #1;
        chk("nop_valid",  {31'd0, valid_wb}, 32'd0);
        chk("nop_regwen", {31'd0, regwen_wb}, 32'd0);
        chk("nop_rd",     {27'd0, rd_wb}, 32'd0);
        chk("nop_fwd",    {30'd0, fwd_rs1, fwd_rs2}, 32'd0);

`ifdef EXE_WB_PERF_CNT_EN
        // WB currently holds a bubble: 10 valid + 2 flush + 3 stall cycles
        ret0 = retired_cnt; bub0 = bubble_cnt;
        drive(ADDI, WB_SEL_ALU, 1'b1, 5'd1);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        for (int i = 0; i < 2; i++) step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("cnt_retired", retired_cnt - ret0, 32'd10);
        chk("cnt_bubble",  bubble_cnt - bub0, 32'd2);
        stall = 1'b0; flush = 1'b0;
`endif

        // Asynchronous reset in the middle of a stall
        drive(ADDI, WB_SEL_ALU, 1'b1, 5'd1);
        step();
        chk("pre_rst_valid", {31'd0, valid_wb}, 32'd1);
        stall = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("async_rst_inst",  inst_wb, 32'h0);
        chk("async_rst_valid", {31'd0, valid_wb}, 32'd0);
        chk("async_rst_ctrl",  {23'd0, wb_sel_wb, regwen_wb, rd_wb, fwd_rs1}, 32'd0);
        chk("async_rst_pc",    pc_wb, 32'h0);
`ifdef EXE_WB_PERF_CNT_EN
        chk("async_rst_cnt",   retired_cnt | bubble_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
